// File: rtl/axi_id_remap_table.sv
// AXI4 ID remapper: folds a wide slave-port ID space onto a small set of
// master-port IDs. It keeps one remap table per direction, each with
// per-entry outstanding-transaction counters, and restores the original
// ID on B/R responses.
// Optional feature macro: AXI_ID_REMAP_STATS_EN adds the per-direction
// stall counters aw_stall_cnt / ar_stall_cnt.
module axi_id_remap_table #(
  parameter int unsigned AXI_SLV_PORT_ID_WIDTH        = 5,
  parameter int unsigned AXI_MST_PORT_ID_WIDTH        = 2,
  parameter int unsigned AXI_MST_PORT_MAX_UNIQ_IDS    = 4,
  parameter int unsigned AXI_MST_PORT_MAX_TXNS_PER_ID = 4,
  parameter int unsigned AXI_ADDR_WIDTH               = 32,
  parameter int unsigned AXI_DATA_WIDTH               = 64,
  parameter int unsigned AXI_USER_WIDTH               = 1
) (
  input  logic                             aclk,
  input  logic                             rstn,
  // slave AW
  input  logic [AXI_SLV_PORT_ID_WIDTH-1:0] s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [7:0]                       s_axi_awlen,
  input  logic [2:0]                       s_axi_awsize,
  input  logic [1:0]                       s_axi_awburst,
  input  logic                             s_axi_awlock,
  input  logic [3:0]                       s_axi_awcache,
  input  logic [2:0]                       s_axi_awprot,
  input  logic [3:0]                       s_axi_awqos,
  input  logic [3:0]                       s_axi_awregion,
  input  logic [5:0]                       s_axi_awatop,
  input  logic [AXI_USER_WIDTH-1:0]        s_axi_awuser,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  // slave W
  input  logic [AXI_DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                             s_axi_wlast,
  input  logic [AXI_USER_WIDTH-1:0]        s_axi_wuser,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  // slave B
  output logic [AXI_SLV_PORT_ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]                       s_axi_bresp,
  output logic [AXI_USER_WIDTH-1:0]        s_axi_buser,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  // slave AR
  input  logic [AXI_SLV_PORT_ID_WIDTH-1:0] s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                       s_axi_arlen,
  input  logic [2:0]                       s_axi_arsize,
  input  logic [1:0]                       s_axi_arburst,
  input  logic                             s_axi_arlock,
  input  logic [3:0]                       s_axi_arcache,
  input  logic [2:0]                       s_axi_arprot,
  input  logic [3:0]                       s_axi_arqos,
  input  logic [3:0]                       s_axi_arregion,
  input  logic [AXI_USER_WIDTH-1:0]        s_axi_aruser,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  // slave R
  output logic [AXI_SLV_PORT_ID_WIDTH-1:0] s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rlast,
  output logic [AXI_USER_WIDTH-1:0]        s_axi_ruser,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  // master AW
  output logic [AXI_MST_PORT_ID_WIDTH-1:0] m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]        m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awlock,
  output logic [3:0]                       m_axi_awcache,
  output logic [2:0]                       m_axi_awprot,
  output logic [3:0]                       m_axi_awqos,
  output logic [3:0]                       m_axi_awregion,
  output logic [5:0]                       m_axi_awatop,
  output logic [AXI_USER_WIDTH-1:0]        m_axi_awuser,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  // master W
  output logic [AXI_DATA_WIDTH-1:0]        m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]      m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic [AXI_USER_WIDTH-1:0]        m_axi_wuser,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  // master B
  input  logic [AXI_MST_PORT_ID_WIDTH-1:0] m_axi_bid,
  input  logic [1:0]                       m_axi_bresp,
  input  logic [AXI_USER_WIDTH-1:0]        m_axi_buser,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  // master AR
  output logic [AXI_MST_PORT_ID_WIDTH-1:0] m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arlock,
  output logic [3:0]                       m_axi_arcache,
  output logic [2:0]                       m_axi_arprot,
  output logic [3:0]                       m_axi_arqos,
  output logic [3:0]                       m_axi_arregion,
  output logic [AXI_USER_WIDTH-1:0]        m_axi_aruser,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  // master R
  input  logic [AXI_MST_PORT_ID_WIDTH-1:0] m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic [AXI_USER_WIDTH-1:0]        m_axi_ruser,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready,
`ifdef AXI_ID_REMAP_STATS_EN
  output logic [31:0]                      aw_stall_cnt,
  output logic [31:0]                      ar_stall_cnt,
`endif
  output logic                             proto_err
);

  localparam int unsigned SW   = AXI_SLV_PORT_ID_WIDTH;
  localparam int unsigned MW   = AXI_MST_PORT_ID_WIDTH;
  localparam int unsigned N    = AXI_MST_PORT_MAX_UNIQ_IDS;
  localparam int unsigned MAXT = AXI_MST_PORT_MAX_TXNS_PER_ID;
  localparam int unsigned CW   = $clog2(MAXT + 1);

  // Index 0 = write table (AW/B), index 1 = read table (AR/R).
  logic          r_valid [2][N];
  logic [SW-1:0] r_sid   [2][N];
  logic [CW-1:0] r_cnt   [2][N];
  logic          r_proto_err;

  logic          w_req_valid [2];
  logic          w_req_rdy   [2];
  logic [SW-1:0] w_req_id    [2];
  logic          w_rsp_hs    [2];
  logic          w_rsp_last  [2];
  logic [MW-1:0] w_rsp_id    [2];
  logic          w_hit       [2];
  logic          w_hit_full  [2];
  logic [MW-1:0] w_hit_idx   [2];
  logic          w_free      [2];
  logic [MW-1:0] w_free_idx  [2];
  logic          w_can       [2];
  logic [MW-1:0] w_idx       [2];
  logic          w_iss       [2];
  logic          w_rsp_ok    [2];
  logic [SW-1:0] w_rsp_sid   [2];
  logic          w_inc       [2][N];
  logic          w_dec       [2][N];
  logic          w_err;

  // Gather both directions into arrays so one lookup body serves AW and AR.
  always_comb begin
    w_req_valid[0] = s_axi_awvalid;
    w_req_valid[1] = s_axi_arvalid;
    w_req_rdy[0]   = m_axi_awready;
    w_req_rdy[1]   = m_axi_arready;
    w_req_id[0]    = s_axi_awid;
    w_req_id[1]    = s_axi_arid;
    w_rsp_hs[0]    = m_axi_bvalid & s_axi_bready;
    w_rsp_hs[1]    = m_axi_rvalid & s_axi_rready;
    w_rsp_last[0]  = 1'b1;
    w_rsp_last[1]  = m_axi_rlast;
    w_rsp_id[0]    = m_axi_bid;
    w_rsp_id[1]    = m_axi_rid;
  end

  // Table lookup: hit / lowest free entry for requests, ID restore for responses.
  always_comb begin
    for (int unsigned d = 0; d < 2; d++) begin
      w_hit[d]      = 1'b0;
      w_hit_full[d] = 1'b0;
      w_hit_idx[d]  = '0;
      w_free[d]     = 1'b0;
      w_free_idx[d] = '0;
      w_rsp_ok[d]   = 1'b0;
      w_rsp_sid[d]  = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (r_valid[d][i] && (r_sid[d][i] == w_req_id[d])) begin
          w_hit[d]      = 1'b1;
          w_hit_full[d] = (r_cnt[d][i] == CW'(MAXT));
          w_hit_idx[d]  = MW'(i);
        end
        if (!r_valid[d][i] && !w_free[d]) begin
          w_free[d]     = 1'b1;
          w_free_idx[d] = MW'(i);
        end
        // IDs at or beyond N never match an entry and fall out as errors.
        if (r_valid[d][i] && (w_rsp_id[d] == MW'(i))) begin
          w_rsp_ok[d]  = 1'b1;
          w_rsp_sid[d] = r_sid[d][i];
        end
      end
      w_can[d] = rstn & (w_hit[d] ? !w_hit_full[d] : w_free[d]);
      w_idx[d] = w_hit[d] ? w_hit_idx[d] : w_free_idx[d];
      w_iss[d] = w_req_valid[d] & w_req_rdy[d] & w_can[d];
      for (int unsigned i = 0; i < N; i++) begin
        w_inc[d][i] = w_iss[d] && (w_idx[d] == MW'(i));
        w_dec[d][i] = w_rsp_hs[d] && w_rsp_last[d] && r_valid[d][i] &&
                      (w_rsp_id[d] == MW'(i));
      end
    end
    w_err = (w_rsp_hs[0] & ~w_rsp_ok[0]) | (w_rsp_hs[1] & ~w_rsp_ok[1]) |
            (w_iss[0] & s_axi_awatop[5]);
  end

  // Entry update: issue increments (allocating if needed), final response
  // beat decrements; an entry reaching zero is released at the same edge, so
  // a freed slot is only visible to allocation from the next cycle.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned d = 0; d < 2; d++) begin
        for (int unsigned i = 0; i < N; i++) begin
          r_valid[d][i] <= 1'b0;
          r_sid[d][i]   <= '0;
          r_cnt[d][i]   <= '0;
        end
      end
    end else begin
      for (int unsigned d = 0; d < 2; d++) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (w_inc[d][i] && !w_dec[d][i]) begin
            r_valid[d][i] <= 1'b1;
            r_cnt[d][i]   <= r_cnt[d][i] + CW'(1);
            if (!r_valid[d][i]) r_sid[d][i] <= w_req_id[d];
          end else if (w_dec[d][i] && !w_inc[d][i]) begin
            r_cnt[d][i] <= r_cnt[d][i] - CW'(1);
            if (r_cnt[d][i] == CW'(1)) r_valid[d][i] <= 1'b0;
          end
        end
      end
    end
  end

  // Sticky protocol-error flag.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) r_proto_err <= 1'b0;
    else if (w_err) r_proto_err <= 1'b1;
  end

  assign proto_err = r_proto_err;

`ifdef AXI_ID_REMAP_STATS_EN
  logic [31:0] r_stall [2];

  // Saturating count of cycles a request waits for a table slot.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      r_stall[0] <= '0;
      r_stall[1] <= '0;
    end else begin
      for (int unsigned d = 0; d < 2; d++) begin
        if (w_req_valid[d] && !w_can[d] && (r_stall[d] != '1))
          r_stall[d] <= r_stall[d] + 32'd1;
      end
    end
  end

  assign aw_stall_cnt = r_stall[0];
  assign ar_stall_cnt = r_stall[1];
`endif

  // AW
  assign m_axi_awid     = w_idx[0];
  assign m_axi_awaddr   = s_axi_awaddr;
  assign m_axi_awlen    = s_axi_awlen;
  assign m_axi_awsize   = s_axi_awsize;
  assign m_axi_awburst  = s_axi_awburst;
  assign m_axi_awlock   = s_axi_awlock;
  assign m_axi_awcache  = s_axi_awcache;
  assign m_axi_awprot   = s_axi_awprot;
  assign m_axi_awqos    = s_axi_awqos;
  assign m_axi_awregion = s_axi_awregion;
  assign m_axi_awatop   = s_axi_awatop;
  assign m_axi_awuser   = s_axi_awuser;
  assign m_axi_awvalid  = s_axi_awvalid & w_can[0];
  assign s_axi_awready  = m_axi_awready & w_can[0];
  // W
  assign m_axi_wdata    = s_axi_wdata;
  assign m_axi_wstrb    = s_axi_wstrb;
  assign m_axi_wlast    = s_axi_wlast;
  assign m_axi_wuser    = s_axi_wuser;
  assign m_axi_wvalid   = rstn & s_axi_wvalid;
  assign s_axi_wready   = rstn & m_axi_wready;
  // B
  assign s_axi_bid      = w_rsp_sid[0];
  assign s_axi_bresp    = m_axi_bresp;
  assign s_axi_buser    = m_axi_buser;
  assign s_axi_bvalid   = rstn & m_axi_bvalid;
  assign m_axi_bready   = rstn & s_axi_bready;
  // AR
  assign m_axi_arid     = w_idx[1];
  assign m_axi_araddr   = s_axi_araddr;
  assign m_axi_arlen    = s_axi_arlen;
  assign m_axi_arsize   = s_axi_arsize;
  assign m_axi_arburst  = s_axi_arburst;
  assign m_axi_arlock   = s_axi_arlock;
  assign m_axi_arcache  = s_axi_arcache;
  assign m_axi_arprot   = s_axi_arprot;
  assign m_axi_arqos    = s_axi_arqos;
  assign m_axi_arregion = s_axi_arregion;
  assign m_axi_aruser   = s_axi_aruser;
  assign m_axi_arvalid  = s_axi_arvalid & w_can[1];
  assign s_axi_arready  = m_axi_arready & w_can[1];
  // R
  assign s_axi_rid      = w_rsp_sid[1];
  assign s_axi_rdata    = m_axi_rdata;
  assign s_axi_rresp    = m_axi_rresp;
  assign s_axi_rlast    = m_axi_rlast;
  assign s_axi_ruser    = m_axi_ruser;
  assign s_axi_rvalid   = rstn & m_axi_rvalid;
  assign m_axi_rready   = rstn & s_axi_rready;

endmodule
